// File: rtl/jtcps1_pkg.sv
// Shared constants and handshake encoding for the CPS1 scroll line buffer.
// Pixel word layout: {group, palette, colour}; colour 4'hF is transparent.
package jtcps1_pkg;
    localparam int GROUP_W = 2;
    localparam int PAL_W   = 5;
    localparam int COL_W   = 4;
    localparam int PXL_W   = GROUP_W + PAL_W + COL_W;
    localparam logic [PXL_W-1:0] BLANK = {PXL_W{1'b1}};

    typedef enum logic [1:0] {
        HS_IDLE     = 2'd0,
        HS_STOPPING = 2'd1,
        HS_REQUEST  = 2'd2
    } hs_state_t;
endpackage

// File: rtl/jtcps1_dpram.sv
// Dual-port line RAM: port A plain write, port B read-old-then-erase.
// Callers guarantee that the two ports never address the same word in one cycle.
module jtcps1_dpram #(
    parameter int              AW    = 10,
    parameter int              DW    = 11,
    parameter logic [DW-1:0]   ERASE = '1
) (
    input  logic          clk,
    input  logic          i_we_a,
    input  logic [AW-1:0] i_addr_a,
    input  logic [DW-1:0] i_din_a,
    input  logic          i_en_b,
    input  logic [AW-1:0] i_addr_b,
    output logic [DW-1:0] o_dout_b
);
    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we_a)
            r_mem[i_addr_a] <= i_din_a;
        if (i_en_b) begin
            o_dout_b         <= r_mem[i_addr_b];
            r_mem[i_addr_b]  <= ERASE;
        end
    end
endmodule

// File: rtl/jtcps1_scroll_linebuf.sv
// Scroll line buffer consumer: double-banked line RAM with erase-on-read scan-out
// and the per-line start/stop/done handshake towards the scroll renderer.
module jtcps1_scroll_linebuf
    import jtcps1_pkg::*;
#(
    parameter int            AW    = 9,
    parameter int            DW    = 11,
    parameter logic [DW-1:0] BLANK = 11'h7FF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic          flip,
    input  logic [AW-1:0] hdump,
    input  logic          line_start,
    output logic          render_start,
    output logic          render_stop,
    input  logic          render_done,
    input  logic [AW-1:0] buf_addr,
    input  logic [DW-1:0] buf_data,
    input  logic          buf_wr,
    output logic [DW-1:0] pxl
);
    logic          r_wr_bank;
    logic [1:0]    r_valid;
    logic          r_pxl_ok;
    logic          w_rd_bank;
    logic [AW-1:0] w_rd_addr;
    logic [DW-1:0] w_rd_data;

    assign w_rd_bank = ~r_wr_bank;
    assign w_rd_addr = flip ? ~hdump : hdump;

    jtcps1_dpram #(.AW(AW+1), .DW(DW), .ERASE(BLANK)) u_ram (
        .clk      (clk),
        .i_we_a   (buf_wr),
        .i_addr_a ({r_wr_bank, buf_addr}),
        .i_din_a  (buf_data),
        .i_en_b   (pxl_cen),
        .i_addr_b ({w_rd_bank, w_rd_addr}),
        .o_dout_b (w_rd_data)
    );

    // r_pxl_ok is captured alongside the RAM read, so the output mux only
    // combines two registers and pxl holds between enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_valid   <= 2'b00;
            r_pxl_ok  <= 1'b0;
        end else begin
            if (line_start) begin
                r_wr_bank          <= ~r_wr_bank;
                r_valid[r_wr_bank] <= 1'b1;
            end
            if (pxl_cen)
                r_pxl_ok <= r_valid[w_rd_bank];
        end
    end

    assign pxl = r_pxl_ok ? w_rd_data : BLANK;

    hs_state_t r_state, w_nxt_state;
    logic      r_start_req, w_nxt_req;
    logic      r_stop, w_nxt_stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HS_IDLE;
            r_start_req <= 1'b0;
            r_stop      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_start_req <= w_nxt_req;
            r_stop      <= w_nxt_stop;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_req   = r_start_req;
        w_nxt_stop  = 1'b0;
        case (r_state)
            HS_IDLE: begin
                if (line_start) begin
                    if (r_start_req) begin
                        w_nxt_state = HS_STOPPING;
                        w_nxt_req   = 1'b0;
                        w_nxt_stop  = 1'b1;
                    end else begin
                        w_nxt_state = HS_REQUEST;
                        w_nxt_req   = 1'b1;
                    end
                end
            end
            HS_STOPPING: begin
                w_nxt_state = HS_REQUEST;
                w_nxt_req   = 1'b1;
            end
            HS_REQUEST: begin
                if (render_done && r_start_req) begin
                    w_nxt_state = HS_IDLE;
                    w_nxt_req   = 1'b0;
                end else if (line_start && r_start_req) begin
                    w_nxt_state = HS_STOPPING;
                    w_nxt_req   = 1'b0;
                    w_nxt_stop  = 1'b1;
                end
            end
            default: begin
                w_nxt_state = HS_IDLE;
                w_nxt_req   = 1'b0;
            end
        endcase
    end

    // Gate with done so the renderer cannot re-trigger in the done cycle.
    assign render_start = r_start_req & ~render_done;
    assign render_stop  = r_stop;
endmodule

// File: tb/tb_jtcps1_scroll_linebuf.sv
// Directed + randomized bench for jtcps1_scroll_linebuf against a per-bank array model.
module tb_jtcps1_scroll_linebuf;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pxl_cen = 1'b0;
    logic        flip = 1'b0;
    logic [8:0]  hdump = '0;
    logic        line_start = 1'b0;
    logic        render_start, render_stop;
    logic        render_done = 1'b0;
    logic [8:0]  buf_addr = '0;
    logic [10:0] buf_data = '0;
    logic        buf_wr = 1'b0;
    logic [10:0] pxl;

    int checks = 0;
    int errors = 0;

    // Model: -1 marks RAM words never written nor erased since power-up.
    int m [2][512];
    int vld [2];
    int wb;
    int ex;
    logic [10:0] got [512];

    always #5 clk = ~clk;

    jtcps1_scroll_linebuf dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .flip(flip), .hdump(hdump),
        .line_start(line_start), .render_start(render_start), .render_stop(render_stop),
        .render_done(render_done), .buf_addr(buf_addr), .buf_data(buf_data),
        .buf_wr(buf_wr), .pxl(pxl)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exv);
        checks++;
        assert (obs === exv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exv);
        end
    endtask

    task automatic tick();
        bit c_rst = rst, c_ls = line_start, c_wr = buf_wr, c_cen = pxl_cen, c_fl = flip;
        int c_h = int'(hdump), c_a = int'(buf_addr), c_d = int'(buf_data);
        int rb, a;
        @(posedge clk);
        if (c_rst) begin
            wb = 0; vld[0] = 0; vld[1] = 0; ex = 'h7FF;
        end else begin
            if (c_cen) begin
                rb = 1 - wb;
                a  = c_fl ? 511 - c_h : c_h;
                ex = vld[rb] ? m[rb][a] : 'h7FF;
                m[rb][a] = 'h7FF;
            end
            if (c_wr) m[wb][c_a] = c_d;
            if (c_ls) begin vld[wb] = 1; wb = 1 - wb; end
        end
        #1;
        if (c_cen && !c_rst && ex >= 0) chk("pxl", pxl, ex);
    endtask

    task automatic randwr(input bit en);
        buf_wr   = en && ($urandom_range(0, 3) == 0);
        buf_addr = 9'($urandom_range(0, 511));
        buf_data = 11'($urandom_range(0, 2047));
    endtask

    task automatic scan_line(input int per, input bit fl, input bit rw);
        for (int h = 0; h < 512; h++) begin
            hdump = 9'(h); flip = fl; pxl_cen = 1'b1;
            randwr(rw);
            tick();
            got[h] = pxl;
            pxl_cen = 1'b0;
            for (int k = 1; k < per; k++) begin randwr(rw); tick(); end
        end
        buf_wr = 1'b0;
    endtask

    task automatic write1(input logic [8:0] a, input logic [10:0] d);
        buf_wr = 1'b1; buf_addr = a; buf_data = d;
        tick();
        buf_wr = 1'b0;
    endtask

    task automatic line_pulse();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic done_pulse();
        render_done = 1'b1;
        #1;
        chk("start_gated_by_done", render_start, 1'b0);
        tick();
        render_done = 1'b0;
    endtask

    initial begin
        for (int b = 0; b < 2; b++) for (int i = 0; i < 512; i++) m[b][i] = -1;
        vld[0] = 0; vld[1] = 0; wb = 0; ex = 'h7FF;
        #1;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_pxl", pxl, 11'h7FF);
        chk("reset_start", render_start, 1'b0);
        chk("reset_stop", render_stop, 1'b0);

        // First line: read bank invalid, everything BLANK; random writes fill bank 0.
        scan_line(4, 1'b0, 1'b1);
        write1(9'h040, 11'h123);
        chk("idle_no_start", render_start, 1'b0);
        line_pulse();
        chk("start_after_first_line", render_start, 1'b1);
        chk("no_stop_from_idle", render_stop, 1'b0);

        // Line B: bank 0 scanned; 0x40 holds the directed write.
        scan_line(1, 1'b0, 1'b1);
        chk("direct_read", got[9'h040], 11'h123);
        chk("start_before_done", render_start, 1'b1);
        done_pulse();
        chk("start_low_after_done", render_start, 1'b0);
        repeat (5) tick();
        chk("no_rerender", render_start, 1'b0);
        write1(9'h040, 11'h123);
        line_pulse();
        chk("start_next_line", render_start, 1'b1);

        // Line C: flipped scan of bank 1; writes to bank 0 kept quiet.
        scan_line(1, 1'b1, 1'b0);
        chk("flip_read", got[9'h1BF], 11'h123);

        // Unfinished line plus a write coinciding with line_start.
        buf_wr = 1'b1; buf_addr = 9'h010; buf_data = 11'h055;
        line_pulse();
        buf_wr = 1'b0;
        chk("stop_pulse", render_stop, 1'b1);
        chk("start_low_stopping", render_start, 1'b0);
        tick();
        chk("stop_one_clk", render_stop, 1'b0);
        chk("start_reasserted", render_start, 1'b1);

        // Line D: bank 0 again after two swaps.
        scan_line(1, 1'b0, 1'b1);
        chk("erased_after_read", got[9'h040], 11'h7FF);
        chk("coincident_write", got[9'h010], 11'h055);

        for (int l = 0; l < 4; l++) begin
            done_pulse();
            line_pulse();
            chk("start_rand_line", render_start, 1'b1);
            scan_line($urandom_range(1, 2), 1'($urandom_range(0, 1)), 1'b1);
        end

        // Reset mid-line: banks invalid, handshake idle.
        for (int h = 0; h < 100; h++) begin
            hdump = 9'(h); pxl_cen = 1'b1; randwr(1'b1); tick();
        end
        pxl_cen = 1'b0; buf_wr = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("midreset_pxl", pxl, 11'h7FF);
        chk("midreset_start", render_start, 1'b0);
        chk("midreset_stop", render_stop, 1'b0);
        scan_line(1, 1'b0, 1'b1);
        line_pulse();
        chk("start_after_reset_line", render_start, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
